// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if - datapath <-> hazard unit bundle.
//   master : datapath side, drives register addresses / control, reads controls
//   slave  : hazard unit side
// Signals: Rs1D/Rs2D/Rs1E/Rs2E/RdE/RdM/RdW (AW), RegWriteM/W, ResultSrcE0,
//   MdStartE, PCSrcE in; ForwardAE/BE (2), StallF/D/E, FlushD/E/M, MdBusy,
//   StallCnt (32) out.
interface hazard_unit_mc_if #(parameter int AW = 5);
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, ResultSrcE0, MdStartE, PCSrcE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy;
  logic [31:0]   StallCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           RegWriteM, RegWriteW, ResultSrcE0, MdStartE, PCSrcE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, MdBusy, StallCnt
  );
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           RegWriteM, RegWriteW, ResultSrcE0, MdStartE, PCSrcE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, MdBusy, StallCnt
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc - hazard unit for a 5-stage RV32 core with multi-cycle
// load-use stall and mul/div freeze.
//   clk, reset : clock, synchronous active-high reset
//   hif        : hazard_unit_mc_if.slave (sources/dests/controls in,
//                forwarding selects, stall/flush enables, MdBusy, StallCnt out)
// Optional: define HAZARD_PERF_EN to build the 32-bit StallF cycle counter;
// otherwise StallCnt is tied to 0.
module hazard_unit_mc #(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4
) (
  input  logic            clk,
  input  logic            reset,
  hazard_unit_mc_if.slave hif
);
  localparam int MAXL = (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;
  localparam int CW   = $clog2(MAXL) + 1;
  localparam logic [AW-1:0] X0 = '0;
  localparam bit LD_MC = (LOAD_LAT > 1);
  localparam bit MD_MC = (MD_LAT > 1);
  localparam bit MD_LONG = (MD_LAT > 2);

  typedef enum logic [1:0] {IDLE, LD_WAIT, MD_BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          md_done_q, md_done_d;
  logic          lwhit, md_go;
  logic          stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_busy;

  // Forwarding: M has priority over W; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs);
    if (rs != X0 && rs == hif.RdM && hif.RegWriteM)      return 2'b10;
    else if (rs != X0 && rs == hif.RdW && hif.RegWriteW) return 2'b01;
    else                                                 return 2'b00;
  endfunction

  assign lwhit = hif.ResultSrcE0 && (hif.RdE != X0) &&
                 (hif.RdE == hif.Rs1D || hif.RdE == hif.Rs2D);
  // md_done masks the still-asserted MdStartE of an op that just finished.
  assign md_go = MD_MC && hif.MdStartE && !md_done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_done_d = md_done_q;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    md_busy   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hif.PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (lwhit) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
          if (LD_MC) begin
            state_d = LD_WAIT;
            cnt_d   = CW'(LOAD_LAT - 2);
          end
        end else if (md_go) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          md_busy = 1'b1;
          if (MD_LONG) begin
            state_d = MD_BUSY;
            cnt_d   = CW'(MD_LAT - 3);
          end
        end
      end
      LD_WAIT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MD_BUSY: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
        md_busy = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Freeze ends this cycle (MD_BUSY exit or the single-cycle MD_LAT==2 case).
    if (md_busy && state_d == IDLE) md_done_d = 1'b1;
    else if (!hif.MdStartE || !stall_e) md_done_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_done_q <= md_done_d;
    end
  end

  // All controls are forced quiet while reset is asserted.
  assign hif.ForwardAE = reset ? 2'b00 : fwd_sel(hif.Rs1E);
  assign hif.ForwardBE = reset ? 2'b00 : fwd_sel(hif.Rs2E);
  assign hif.StallF    = stall_f && !reset;
  assign hif.StallD    = stall_d && !reset;
  assign hif.StallE    = stall_e && !reset;
  assign hif.FlushD    = flush_d && !reset;
  assign hif.FlushE    = flush_e && !reset;
  assign hif.FlushM    = flush_m && !reset;
  assign hif.MdBusy    = md_busy && !reset;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (reset)           stall_cnt_q <= '0;
    else if (hif.StallF) stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign hif.StallCnt = stall_cnt_q;
`else
  assign hif.StallCnt = '0;
`endif
endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  hazard_unit_mc_if #(.AW(5)) ia ();
  hazard_unit_mc_if #(.AW(5)) ib ();

  // a: LOAD_LAT=3, MD_LAT=4   b: LOAD_LAT=4, MD_LAT=1
  hazard_unit_mc #(.AW(5), .LOAD_LAT(3), .MD_LAT(4)) dut_a (.clk(clk), .reset(rst_a), .hif(ia.slave));
  hazard_unit_mc #(.AW(5), .LOAD_LAT(4), .MD_LAT(1)) dut_b (.clk(clk), .reset(rst_b), .hif(ib.slave));

  // {StallF,StallD,StallE,FlushD,FlushE,FlushM,MdBusy}
  logic [6:0] ctl_a, ctl_b;
  assign ctl_a = {ia.StallF, ia.StallD, ia.StallE, ia.FlushD, ia.FlushE, ia.FlushM, ia.MdBusy};
  assign ctl_b = {ib.StallF, ib.StallD, ib.StallE, ib.FlushD, ib.FlushE, ib.FlushM, ib.MdBusy};

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LD   = 7'b1100100;
  localparam logic [6:0] C_MD   = 7'b1110011;
  localparam logic [6:0] C_BR   = 7'b0001100;

`ifdef HAZARD_PERF_EN
  localparam int LD3_CNT = 3;
`else
  localparam int LD3_CNT = 0;
`endif

  // Advance one cycle; inputs are changed 1 unit after the edge, checks 1 unit later.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    ia.Rs1D = 0; ia.Rs2D = 0; ia.Rs1E = 0; ia.Rs2E = 0;
    ia.RdE = 0; ia.RdM = 0; ia.RdW = 0;
    ia.RegWriteM = 0; ia.RegWriteW = 0; ia.ResultSrcE0 = 0;
    ia.MdStartE = 0; ia.PCSrcE = 0;
  endtask

  task automatic clear_b();
    ib.Rs1D = 0; ib.Rs2D = 0; ib.Rs1E = 0; ib.Rs2E = 0;
    ib.RdE = 0; ib.RdM = 0; ib.RdW = 0;
    ib.RegWriteM = 0; ib.RegWriteW = 0; ib.ResultSrcE0 = 0;
    ib.MdStartE = 0; ib.PCSrcE = 0;
  endtask

  task automatic test_reset();
    rst_a = 1; rst_b = 1;
    clear_a(); clear_b();
    // Inputs that would otherwise raise every hazard control.
    ia.PCSrcE = 1; ia.MdStartE = 1; ia.ResultSrcE0 = 1; ia.RdE = 7; ia.Rs1D = 7;
    ia.RegWriteM = 1; ia.RdM = 5; ia.Rs1E = 5; ia.Rs2E = 5;
    ib.ResultSrcE0 = 1; ib.RdE = 3; ib.Rs2D = 3;
    next_cyc(); #1;
    nvec++; if (ctl_a !== C_NONE) begin nerr++; $display("FAIL reset_ctl_a got %b want %b", ctl_a, C_NONE); end
    nvec++; if ({ia.ForwardAE, ia.ForwardBE} !== 4'b0000) begin nerr++; $display("FAIL reset_fwd_a got %b want 0000", {ia.ForwardAE, ia.ForwardBE}); end
    nvec++; if (ctl_b !== C_NONE) begin nerr++; $display("FAIL reset_ctl_b got %b want %b", ctl_b, C_NONE); end
    next_cyc(); #1;
    nvec++; if (ia.StallCnt !== 32'd0) begin nerr++; $display("FAIL reset_cnt_a got %0d want 0", ia.StallCnt); end
    next_cyc();
    rst_a = 0; rst_b = 0;
    clear_a(); clear_b();
    #1;
    nvec++; if (ctl_a !== C_NONE) begin nerr++; $display("FAIL post_reset_a got %b want %b", ctl_a, C_NONE); end
  endtask

  task automatic test_forward();
    ia.RdM = 5; ia.RdW = 5; ia.Rs1E = 5; ia.RegWriteM = 1; ia.RegWriteW = 1; #1;
    nvec++; if (ia.ForwardAE !== 2'b10) begin nerr++; $display("FAIL fwd_m_prio got %b want 10", ia.ForwardAE); end
    ia.RegWriteM = 0; #1;
    nvec++; if (ia.ForwardAE !== 2'b01) begin nerr++; $display("FAIL fwd_w got %b want 01", ia.ForwardAE); end
    ia.Rs1E = 0; ia.RdM = 0; ia.RdW = 0; ia.RegWriteM = 1; #1;
    nvec++; if (ia.ForwardAE !== 2'b00) begin nerr++; $display("FAIL fwd_x0 got %b want 00", ia.ForwardAE); end
    ia.RdM = 3; ia.RdW = 9; ia.Rs2E = 9; ia.Rs1E = 3; ia.RegWriteM = 1; ia.RegWriteW = 1; #1;
    nvec++; if ({ia.ForwardAE, ia.ForwardBE} !== 4'b1001) begin nerr++; $display("FAIL fwd_ab got %b want 1001", {ia.ForwardAE, ia.ForwardBE}); end
    ia.RegWriteW = 0; #1;
    nvec++; if (ia.ForwardBE !== 2'b00) begin nerr++; $display("FAIL fwd_b_nowr got %b want 00", ia.ForwardBE); end
    nvec++; if (ctl_a !== C_NONE) begin nerr++; $display("FAIL fwd_no_ctl got %b want %b", ctl_a, C_NONE); end
    clear_a();
  endtask

  task automatic test_x0_load();
    ia.ResultSrcE0 = 1; ia.RdE = 0; ia.Rs1D = 0; #1;
    nvec++; if (ctl_a !== C_NONE) begin nerr++; $display("FAIL x0_load got %b want %b", ctl_a, C_NONE); end
    ia.RdE = 7; ia.Rs1D = 3; ia.Rs2D = 4; #1;
    nvec++; if (ctl_a !== C_NONE) begin nerr++; $display("FAIL load_nohit got %b want %b", ctl_a, C_NONE); end
    next_cyc(); #1;
    nvec++; if (ctl_a !== C_NONE) begin nerr++; $display("FAIL load_nohit_next got %b want %b", ctl_a, C_NONE); end
    clear_a();
  endtask

  task automatic test_load_use();
    logic [31:0] base;
    base = ia.StallCnt;
    ia.ResultSrcE0 = 1; ia.RdE = 7; ia.Rs2D = 7; #1;
    nvec++; if (ctl_a !== C_LD) begin nerr++; $display("FAIL ld_c1 got %b want %b", ctl_a, C_LD); end
    next_cyc();
    ia.ResultSrcE0 = 0; ia.RdE = 0; #1;   // E now holds the bubble
    nvec++; if (ctl_a !== C_LD) begin nerr++; $display("FAIL ld_c2 got %b want %b", ctl_a, C_LD); end
    next_cyc(); #1;
    nvec++; if (ctl_a !== C_LD) begin nerr++; $display("FAIL ld_c3 got %b want %b", ctl_a, C_LD); end
    next_cyc(); #1;
    nvec++; if (ctl_a !== C_NONE) begin nerr++; $display("FAIL ld_c4 got %b want %b", ctl_a, C_NONE); end
    nvec++; if (ia.StallCnt - base !== 32'(LD3_CNT)) begin nerr++; $display("FAIL ld_stallcnt got %0d want %0d", ia.StallCnt - base, LD3_CNT); end
    clear_a();
  endtask

  task automatic test_muldiv();
    ia.MdStartE = 1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      nvec++; if (ctl_a !== C_MD) begin nerr++; $display("FAIL md_c%0d got %b want %b", c, ctl_a, C_MD); end
      next_cyc();
    end
    #1;   // cycle 4: same op, released
    nvec++; if (ctl_a !== C_NONE) begin nerr++; $display("FAIL md_c4 got %b want %b", ctl_a, C_NONE); end
    next_cyc();
    ia.MdStartE = 0; #1;
    nvec++; if (ctl_a !== C_NONE) begin nerr++; $display("FAIL md_c5 got %b want %b", ctl_a, C_NONE); end
    next_cyc();
  endtask

  task automatic test_back_to_back();
    // Fresh op after a gap freezes again; during MD_BUSY branch/load are ignored.
    ia.MdStartE = 1; #1;
    nvec++; if (ctl_a !== C_MD) begin nerr++; $display("FAIL b2b_c1 got %b want %b", ctl_a, C_MD); end
    next_cyc();
    ia.PCSrcE = 1; ia.ResultSrcE0 = 1; ia.RdE = 6; ia.Rs1D = 6; #1;
    nvec++; if (ctl_a !== C_MD) begin nerr++; $display("FAIL b2b_ignore got %b want %b", ctl_a, C_MD); end
    next_cyc();
    ia.PCSrcE = 0; ia.ResultSrcE0 = 0; #1;
    nvec++; if (ctl_a !== C_MD) begin nerr++; $display("FAIL b2b_c3 got %b want %b", ctl_a, C_MD); end
    next_cyc(); #1;
    nvec++; if (ctl_a !== C_NONE) begin nerr++; $display("FAIL b2b_c4 got %b want %b", ctl_a, C_NONE); end
    next_cyc();
    clear_a(); #1;
  endtask

  task automatic test_md1();
    ib.MdStartE = 1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      nvec++; if (ctl_b !== C_NONE) begin nerr++; $display("FAIL md1_c%0d got %b want %b", c, ctl_b, C_NONE); end
      next_cyc();
    end
    clear_b();
  endtask

  task automatic test_branch();
    ia.PCSrcE = 1; ia.ResultSrcE0 = 1; ia.RdE = 7; ia.Rs1D = 7; #1;
    nvec++; if (ctl_a !== C_BR) begin nerr++; $display("FAIL br_vs_ld got %b want %b", ctl_a, C_BR); end
    next_cyc();
    clear_a(); #1;
    nvec++; if (ctl_a !== C_NONE) begin nerr++; $display("FAIL br_stay_idle got %b want %b", ctl_a, C_NONE); end
    ia.PCSrcE = 1; ia.MdStartE = 1; #1;
    nvec++; if (ctl_a !== C_BR) begin nerr++; $display("FAIL br_vs_md got %b want %b", ctl_a, C_BR); end
    next_cyc();
    clear_a(); #1;
    nvec++; if (ctl_a !== C_NONE) begin nerr++; $display("FAIL br_md_idle got %b want %b", ctl_a, C_NONE); end
    next_cyc();
  endtask

  task automatic test_reset_ldwait();
    ib.ResultSrcE0 = 1; ib.RdE = 9; ib.Rs1D = 9; #1;
    nvec++; if (ctl_b !== C_LD) begin nerr++; $display("FAIL rld_c1 got %b want %b", ctl_b, C_LD); end
    next_cyc();
    clear_b(); #1;
    nvec++; if (ctl_b !== C_LD) begin nerr++; $display("FAIL rld_c2_pre got %b want %b", ctl_b, C_LD); end
    rst_b = 1; #1;
    nvec++; if (ctl_b !== C_NONE) begin nerr++; $display("FAIL rld_c2_rst got %b want %b", ctl_b, C_NONE); end
    next_cyc();
    rst_b = 0; #1;
    nvec++; if (ctl_b !== C_NONE) begin nerr++; $display("FAIL rld_c3 got %b want %b", ctl_b, C_NONE); end
    nvec++; if (ib.StallCnt !== 32'd0) begin nerr++; $display("FAIL rld_cnt got %0d want 0", ib.StallCnt); end
    next_cyc(); #1;
    nvec++; if (ctl_b !== C_NONE) begin nerr++; $display("FAIL rld_c4 got %b want %b", ctl_b, C_NONE); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_x0_load();
    test_load_use();
    test_muldiv();
    test_back_to_back();
    test_md1();
    test_branch();
    test_reset_ldwait();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor to the pipeline hazard unit, for the 5-stage RV32 core with multi-cycle load and mul/div support.
- Performs E-stage operand forwarding, load-use stall, branch flush and multi-cycle mul/div freeze.
- Load-use stall length is configurable, and register x0 is excluded from stall matching.
- Sits beside the datapath and drives pipeline-register enables and clears.

Parameters:
AW, 5, register address width
LOAD_LAT, 1, load-use stall cycles (>=1); 1 = classic single bubble
MD_LAT, 4, cycles a mul/div op occupies E (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
Rs1D, Rs2D  in  AW  D-stage source regs
Rs1E, Rs2E  in  AW  E-stage source regs
RdE, RdM, RdW  in  AW  destination regs in E/M/W
RegWriteM, RegWriteW  in  1  M/W write enables
ResultSrcE0  in  1  E-stage instr is a load
MdStartE  in  1  E-stage instr is mul/div (held while frozen)
PCSrcE  in  1  taken branch/jump in E
ForwardAE, ForwardBE  out  2  00 regfile, 01 W, 10 M
StallF, StallD, StallE  out  1  hold PC / IF-ID / ID-EX
FlushD, FlushE, FlushM  out  1  clear IF-ID / ID-EX / EX-MEM
MdBusy  out  1  mul/div freeze active
StallCnt  out  32  perf counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset: state=IDLE, cnt=0, StallCnt=0.
  - While `reset` is high, all Stall*/Flush*/MdBusy = 0 and Forward* = 00, regardless of inputs.
- Forwarding (combinational, all states):
  - ForwardAE=10 if Rs1E==RdM & RegWriteM & Rs1E!=0.
  - Else ForwardAE=01 if Rs1E==RdW & RegWriteW & Rs1E!=0.
  - Else ForwardAE=00.
  - ForwardBE uses the same rules on Rs2E.
- lwhit = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- FSM states: IDLE, LD_WAIT, MD_BUSY; down-counter cnt, width $clog2(max(LOAD_LAT,MD_LAT))+1.
- IDLE, priority order:
  1. PCSrcE: FlushD=1, FlushE=1, no stall, stay IDLE. lwhit and MdStartE are ignored this cycle.
  2. lwhit: StallF=StallD=1, FlushE=1. If LOAD_LAT>1, go to LD_WAIT with cnt=LOAD_LAT-2; otherwise stay IDLE.
  3. MdStartE and MD_LAT>1: StallF=StallD=StallE=1, FlushM=1, MdBusy=1. If MD_LAT>2, go to MD_BUSY with cnt=MD_LAT-3; otherwise stay IDLE for one released cycle.
  4. Otherwise all stalls/flushes are 0.
- LD_WAIT:
  - StallF=StallD=1, FlushE=1.
  - If cnt==0, next state IDLE; else cnt--.
  - lwhit is not re-evaluated; E holds a bubble.
  - Total stall for one load-use = LOAD_LAT cycles.
- MD_BUSY:
  - StallF=StallD=StallE=1, FlushM=1, MdBusy=1.
  - If cnt==0, next state IDLE; else cnt--.
  - PCSrcE and lwhit are ignored because E holds the mul/div op.
  - Total freeze = MD_LAT-1 cycles; the op leaves E on cycle MD_LAT.
- Re-entry after MD_BUSY:
  - The first IDLE cycle after MD_BUSY, MdStartE is still high for the same op.
  - The unit must not restart: a 1-bit md_done flag is set on exit and cleared when MdStartE drops or the next cycle ends with StallE=0.
- Reset mid-operation: state and cnt are cleared on the clock edge that samples `reset` high; outputs are 0 from that cycle.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: StallCnt is a 32-bit counter that increments every cycle StallF=1.
  - It wraps at 2^32-1 → 0.
  - Reset clears it to 0.
- Undefined: StallCnt is tied to 0 and no counter flops are generated.

Test Plan:
- Forward priority: RdM=RdW=5, Rs1E=5, RegWriteM=RegWriteW=1 → ForwardAE=10. Drop RegWriteM → 01. Set Rs1E=0 → 00.
- Load-use, LOAD_LAT=3: ResultSrcE0=1, RdE=7, Rs2D=7 → StallF/StallD/FlushE high for exactly 3 cycles, then low; StallCnt +3 (with macro).
- x0 load: ResultSrcE0=1, RdE=0, Rs1D=0 → no stall.
- Mul/div, MD_LAT=4: MdStartE held high 4 cycles → StallE/MdBusy/FlushM high for exactly 3 cycles, no second freeze. MD_LAT=1 → never stalls.
- Branch vs load: PCSrcE=1 with lwhit conditions true → FlushD=FlushE=1, StallF=0, state stays IDLE.
- Reset in LD_WAIT (LOAD_LAT=4, cycle 2): assert reset 1 cycle → all outputs 0 that cycle; next cycle IDLE with no residual stall.
